multicycle_control_unit: RTL
============================

// Module: multicycle_control_unit
// PURPOSE
//   Moore-FSM control unit for the multi-cycle MIPS datapath; next generation of the single-cycle decoder.
//   Decodes op/func once per instruction, sequences FETCH..WRITEBACK and drives per-state datapath strobes.
//   Parametrised ALU-op width and memory latency; adds addi/j support and illegal-opcode detection.
// PARAMETERS
//   ALUOP_W  3  width of ALU_op; encodings below are zero-extended to ALUOP_W (>=3)
//   MEM_LAT  1  cycles each memory state (FETCH, MEMRD, MEMWR) is held, 1..15
// PORTS
//   clk         in   1        rising-edge clock
//   rst_n       in   1        asynchronous active-low reset
//   op          in   6        instruction[31:26], valid from DECODE onward (IR output)
//   func        in   6        instruction[5:0]
//   zero        in   1        ALU zero flag, sampled in BRANCH
//   pc_en       out  1        PC load = PCWrite | (Branch & zero)
//   IorD        out  1        memory address mux: 0=PC, 1=ALUOut
//   MemRead     out  1        memory read strobe
//   MemWrite    out  1        memory write strobe
//   IRWrite     out  1        instruction register load
//   RegDst      out  1        write reg: 0=rt, 1=rd
//   MemtoReg    out  1        write data: 0=ALUOut, 1=MDR
//   RegWrite    out  1        register file write
//   ALUSrcA     out  1        0=PC, 1=A
//   ALUSrcB     out  2        00=B, 01=4, 10=signext imm, 11=signext imm<<2
//   PCSource    out  2        00=ALU, 01=ALUOut, 10=jump target
//   ALU_op      out  ALUOP_W  010 add, 110 sub, 000 and, 001 or, 111 slt
//   illegal_op  out  1        one-cycle pulse in DECODE on unsupported op/func
//   state       out  4        current state, debug
// BEHAVIOUR
//   States: RST=F, FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7,
//     BRANCH=8, JUMP=9, ADDIEX=A, ADDIWB=B. Outputs are pure decodes of state (Moore), except pc_en uses zero.
//   Reset: async to RST, latency counter=0. RST drives all outputs 0; next edge -> FETCH. Reset mid-instruction
//     aborts immediately; no write strobe is ever asserted in RST.
//   Unlisted outputs are 0 in each state; ALU_op defaults to add.
//   FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01. Held MEM_LAT cycles via counter;
//     IRWrite=1, PCWrite=1, PCSource=00 ONLY on last cycle -> DECODE.
//   DECODE: ALUSrcA=0, ALUSrcB=11, add. op 23/2B->MEMADR; 00->EXEC if func legal; 04->BRANCH; 02->JUMP;
//     08->ADDIEX; else illegal_op=1 and ->FETCH (instruction is a NOP, no state changed).
//   MEMADR: ALUSrcA=1, ALUSrcB=10, add; lw->MEMRD, sw->MEMWR.
//   MEMRD: MemRead=1, IorD=1 for MEM_LAT cycles -> MEMWB. MEMWB: RegWrite=1, RegDst=0, MemtoReg=1 -> FETCH.
//   MEMWR: MemWrite=1, IorD=1 for MEM_LAT cycles -> FETCH (MemWrite held all MEM_LAT cycles).
//   EXEC: ALUSrcA=1, ALUSrcB=00, ALU_op from func: 20 add, 22 sub, 24 and, 25 or, 2A slt -> RWB.
//   RWB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
//   BRANCH: ALUSrcA=1, ALUSrcB=00, sub, Branch=1, PCSource=01 -> FETCH; pc_en=zero.
//   JUMP: PCWrite=1, PCSource=10 -> FETCH. ADDIEX: ALUSrcA=1, ALUSrcB=10, add -> ADDIWB.
//   ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
//   Counter: 4 bits, cleared on every state change, saturates never (MEM_LAT<=15); MEM_LAT=1 => no hold.
//   op/func are sampled combinationally in DECODE and EXEC only; changes elsewhere ignored.
//   Cycles/instr (MEM_LAT=1): R 4, lw 5, sw 4, beq 3, j 3, addi 4; each memory state adds MEM_LAT-1.
//   Unreachable state encodings (C..E) -> FETCH next cycle, outputs 0.
// TESTING
//   Reset release, op=00 func=20 -> state F,0,1,6,7,0; RegWrite=1 only in RWB with RegDst=1; ALU_op=010.
//   lw (op=23), MEM_LAT=3 -> FETCH 3 cycles, IRWrite only in 3rd; MEMRD 3 cycles; total 9 cycles to FETCH.
//   beq (op=04) zero=1 -> pc_en=1 in BRANCH; zero=0 -> pc_en=0; ALU_op=110 both cases.
//   op=3F or op=00 func=3F -> illegal_op=1 for one DECODE cycle, next state FETCH, no Reg/MemWrite.
//   sw (op=2B), assert rst_n=0 mid-MEMWR -> MemWrite drops asynchronously, state=F, then FETCH.
//   j (op=02) -> JUMP with PCWrite/pc_en=1, PCSource=10; addi (op=08) -> A,B, RegDst=0, RegWrite=1.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multi-cycle MIPS datapath: sequences FETCH..WRITEBACK per instruction
// and decodes per-state datapath strobes; memory states are held MEM_LAT cycles by a small counter.
module multicycle_control_unit #(
    parameter int ALUOP_W = 3,
    parameter int MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic [5:0]         func,
    input  logic               zero,
    output logic               pc_en,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALU_op,
    output logic               illegal_op,
    output logic [3:0]         state
);
    localparam logic [3:0] S_FETCH  = 4'h0;
    localparam logic [3:0] S_DECODE = 4'h1;
    localparam logic [3:0] S_MEMADR = 4'h2;
    localparam logic [3:0] S_MEMRD  = 4'h3;
    localparam logic [3:0] S_MEMWB  = 4'h4;
    localparam logic [3:0] S_MEMWR  = 4'h5;
    localparam logic [3:0] S_EXEC   = 4'h6;
    localparam logic [3:0] S_RWB    = 4'h7;
    localparam logic [3:0] S_BRANCH = 4'h8;
    localparam logic [3:0] S_JUMP   = 4'h9;
    localparam logic [3:0] S_ADDIEX = 4'hA;
    localparam logic [3:0] S_ADDIWB = 4'hB;
    localparam logic [3:0] S_RST    = 4'hF;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;

    localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

    logic [3:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       is_sw_q, is_sw_d;
    logic       mem_last;
    logic       func_ok;
    logic [2:0] func_alu;
    logic [2:0] alu3;
    logic       pc_write;
    logic       branch;

    assign mem_last = (cnt_q == CNT_LAST);

    always_comb begin
        func_ok  = 1'b1;
        func_alu = 3'b010;
        case (func)
            6'h20:   func_alu = 3'b010;
            6'h22:   func_alu = 3'b110;
            6'h24:   func_alu = 3'b000;
            6'h25:   func_alu = 3'b001;
            6'h2A:   func_alu = 3'b111;
            default: func_ok  = 1'b0;
        endcase
    end

    // lw/sw is captured in DECODE so MEMADR never has to look at op again.
    always_comb begin
        state_d    = state_q;
        is_sw_d    = is_sw_q;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_last) state_d = S_DECODE;
            S_DECODE: begin
                is_sw_d = (op == OP_SW);
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R: begin
                        if (func_ok) begin
                            state_d = S_EXEC;
                        end else begin
                            state_d    = S_FETCH;
                            illegal_op = 1'b1;
                        end
                    end
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_J:    state_d = S_JUMP;
                    OP_ADDI: state_d = S_ADDIEX;
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_last) state_d = S_MEMWB;
            S_MEMWR:  if (mem_last) state_d = S_FETCH;
            S_EXEC:   state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
        cnt_d = (state_d != state_q) ? 4'd0 : cnt_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            cnt_q   <= 4'd0;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_sw_q <= is_sw_d;
        end
    end

    always_comb begin
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        PCSource = 2'b00;
        alu3     = 3'b010;
        pc_write = 1'b0;
        branch   = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_last) begin
                    IRWrite  = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                alu3    = func_alu;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                alu3     = 3'b110;
                branch   = 1'b1;
                PCSource = 2'b01;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                PCSource = 2'b10;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: RegWrite = 1'b1;
            default:  alu3 = 3'b000;
        endcase
    end

    assign ALU_op = ALUOP_W'(alu3);
    assign pc_en  = pc_write | (branch & zero);
    assign state  = state_q;
endmodule
